// File: rtl/msrh_snoop_req_arb.sv
// Round-robin arbiter sharing one snoop unit between REQ_N coherence requesters.
// Optional response watchdog: define MSRH_SNOOP_ARB_TIMEOUT_EN.
module msrh_snoop_req_arb #(
    parameter int unsigned REQ_N       = 4,
    parameter int unsigned PADDR_W     = 56,
    parameter int unsigned DATA_W      = 512,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [REQ_N-1:0]              i_req_valid,
    input  logic [REQ_N-1:0][PADDR_W-1:0] i_req_paddr,
    output logic [REQ_N-1:0]              o_req_ready,
    output logic [REQ_N-1:0]              o_resp_valid,
    output logic [DATA_W-1:0]             o_resp_data,
    output logic [DATA_W/8-1:0]           o_resp_be,
    output logic                          o_resp_err,
    output logic                          o_snp_req_valid,
    output logic [PADDR_W-1:0]            o_snp_req_paddr,
    input  logic                          i_snp_resp_valid,
    input  logic [DATA_W-1:0]             i_snp_resp_data,
    input  logic [DATA_W/8-1:0]           i_snp_resp_be,
    output logic                          o_busy
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned ID_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

`ifdef MSRH_SNOOP_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DRAIN} state_e;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_e;
`endif

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [PADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0]  data_q;
    logic [BE_W-1:0]    be_q;
    logic [REQ_N-1:0]   resp_valid_q;
    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic               resp_take;
    logic               timeout_hit;

`ifdef MSRH_SNOOP_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]   cnt_q;
    logic               resp_err_q;
`endif

    // Round-robin search starting at rr_ptr_q, wrapping REQ_N-1 -> 0.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int unsigned k = 0; k < REQ_N; k++) begin
            idx = (32'(rr_ptr_q) + k) % REQ_N;
            if (!grant_found && i_req_valid[ID_W'(idx)]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    assign resp_take   = (state_q == WAIT_RESP) && i_snp_resp_valid;
`ifdef MSRH_SNOOP_ARB_TIMEOUT_EN
    assign timeout_hit = (state_q == WAIT_RESP) && !i_snp_resp_valid &&
                         (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (grant_found) state_d = ISSUE;
            ISSUE:     state_d = WAIT_RESP;
            WAIT_RESP: begin
                if (resp_take)        state_d = IDLE;
`ifdef MSRH_SNOOP_ARB_TIMEOUT_EN
                else if (timeout_hit) state_d = DRAIN;
            end
            DRAIN:     begin
                // Swallow the late response of the timed-out snoop.
                if (i_snp_resp_valid) state_d = IDLE;
`endif
            end
            default:   state_d = IDLE;
        endcase
    end

    // Grant latch, response capture and pointer update.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rr_ptr_q     <= '0;
            id_q         <= '0;
            paddr_q      <= '0;
            data_q       <= '0;
            be_q         <= '0;
            resp_valid_q <= '0;
        end else begin
            resp_valid_q <= '0;
            if ((state_q == IDLE) && grant_found) begin
                id_q     <= grant_id;
                paddr_q  <= i_req_paddr[grant_id];
                rr_ptr_q <= ID_W'((32'(grant_id) + 1) % REQ_N);
            end
            if (resp_take) begin
                data_q       <= i_snp_resp_data;
                be_q         <= i_snp_resp_be;
                resp_valid_q <= REQ_N'(1) << id_q;
            end else if (timeout_hit) begin
                data_q       <= '0;
                be_q         <= '0;
                resp_valid_q <= REQ_N'(1) << id_q;
            end
        end
    end

`ifdef MSRH_SNOOP_ARB_TIMEOUT_EN
    // Watchdog: cleared while issuing, counts every WAIT_RESP cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q      <= '0;
            resp_err_q <= 1'b0;
        end else begin
            if (state_q == ISSUE)          cnt_q <= '0;
            else if (state_q == WAIT_RESP) cnt_q <= cnt_q + CNT_W'(1);
            resp_err_q <= timeout_hit;
        end
    end
    assign o_resp_err = resp_err_q;
`else
    assign o_resp_err = 1'b0;
`endif

    assign o_req_ready     = ((state_q == IDLE) && grant_found) ? (REQ_N'(1) << grant_id) : '0;
    assign o_resp_valid    = resp_valid_q;
    assign o_resp_data     = data_q;
    assign o_resp_be       = be_q;
    assign o_snp_req_valid = (state_q == ISSUE);
    assign o_snp_req_paddr = paddr_q;
    assign o_busy          = (state_q != IDLE);

`ifndef SYNTHESIS
    if (REQ_N < 2 || TIMEOUT_CYC < 2) begin : g_cfg_check
        $error("msrh_snoop_req_arb: REQ_N and TIMEOUT_CYC must be >= 2");
    end

    snp_resp_in_wait: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        i_snp_resp_valid |-> (state_q == WAIT_RESP) || (o_busy && !o_snp_req_valid && (state_q != WAIT_RESP) && (state_q != IDLE)))
        else $warning("msrh_snoop_req_arb: snoop response outside WAIT_RESP ignored");
`endif

endmodule

// File: tb/tb_msrh_snoop_req_arb.sv
// Directed table-driven bench for msrh_snoop_req_arb (REQ_N=4, TIMEOUT_CYC=16).
module tb_msrh_snoop_req_arb;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req_valid;
    logic [3:0][55:0]  req_paddr;
    logic [3:0]        req_ready;
    logic [3:0]        resp_valid;
    logic [511:0]      resp_data;
    logic [63:0]       resp_be;
    logic              resp_err;
    logic              snp_req_valid;
    logic [55:0]       snp_req_paddr;
    logic              snp_resp_valid;
    logic [511:0]      snp_resp_data;
    logic [63:0]       snp_resp_be;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int gcnt[4];

    always #5 clk = ~clk;

    msrh_snoop_req_arb #(
        .REQ_N(4), .PADDR_W(56), .DATA_W(512), .TIMEOUT_CYC(16)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid), .i_req_paddr(req_paddr), .o_req_ready(req_ready),
        .o_resp_valid(resp_valid), .o_resp_data(resp_data), .o_resp_be(resp_be),
        .o_resp_err(resp_err),
        .o_snp_req_valid(snp_req_valid), .o_snp_req_paddr(snp_req_paddr),
        .i_snp_resp_valid(snp_resp_valid), .i_snp_resp_data(snp_resp_data),
        .i_snp_resp_be(snp_resp_be),
        .o_busy(busy)
    );

    typedef struct {
        logic [3:0] valid;
        logic       rsp;
        logic [7:0] seed;
        logic [3:0] ex_ready;
        logic       ex_snp;
        logic [1:0] ex_pid;
        logic [3:0] ex_rv;
        logic [7:0] ex_seed;
        logic       ex_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [511:0] pat(input logic [7:0] s);
        return {8{s, 56'h01_2345_6789_ABCD}};
    endfunction

    function automatic void add(input logic [3:0] v, input logic r, input logic [7:0] s,
                                input logic [3:0] er, input logic es, input logic [1:0] ep,
                                input logic [3:0] erv, input logic [7:0] esd, input logic eb);
        vec_t t;
        t = '{v, r, s, er, es, ep, erv, esd, eb};
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic r, input logic [7:0] s);
        @(posedge clk);
        #1;
        req_valid      = v;
        snp_resp_valid = r;
        snp_resp_data  = r ? pat(s) : '0;
        snp_resp_be    = r ? {8{s}} : '0;
        @(negedge clk);
    endtask

    task automatic chk_resp(input string name, input logic [3:0] rv, input logic [7:0] s);
        chk({name, "_rv"}, 512'(resp_valid), 512'(rv));
        chk({name, "_data"}, resp_data, pat(s));
        chk({name, "_be"}, 512'(resp_be), 512'({8{s}}));
        chk({name, "_err"}, 512'(resp_err), 512'(0));
    endtask

    initial begin
        logic [3:0] w1;
        req_paddr[0] = 56'h00_0000_0000_1000;
        req_paddr[1] = 56'h12_3456_7880;
        req_paddr[2] = 56'h00_8000_1040;
        req_paddr[3] = 56'hFF_FFFF_FFFF_FFC0;
        req_valid = '0; snp_resp_valid = 1'b0; snp_resp_data = '0; snp_resp_be = '0;
        for (int i = 0; i < 4; i++) gcnt[i] = 0;

        // Single request from requester 2 (pointer 0).
        add(4'b0100, 0, 8'h00, 4'b0100, 0, 0, 4'b0000, 8'h00, 0);
        add(4'b0000, 0, 8'h00, 4'b0000, 1, 2, 4'b0000, 8'h00, 1);
        add(4'b0000, 0, 8'h00, 4'b0000, 0, 0, 4'b0000, 8'h00, 1);
        add(4'b0000, 1, 8'hFF, 4'b0000, 0, 0, 4'b0000, 8'h00, 1);
        add(4'b0000, 0, 8'h00, 4'b0000, 0, 0, 4'b0100, 8'hFF, 0);
        // Requester 3 then 0 (wrap) then 3; back-to-back grant with response.
        add(4'b1001, 0, 8'h00, 4'b1000, 0, 0, 4'b0000, 8'h00, 0);
        add(4'b1001, 0, 8'h00, 4'b0000, 1, 3, 4'b0000, 8'h00, 1);
        add(4'b1001, 0, 8'h00, 4'b0000, 0, 0, 4'b0000, 8'h00, 1);
        add(4'b1001, 0, 8'h00, 4'b0000, 0, 0, 4'b0000, 8'h00, 1);
        add(4'b1001, 1, 8'h3C, 4'b0000, 0, 0, 4'b0000, 8'h00, 1);
        add(4'b1001, 0, 8'h00, 4'b0001, 0, 0, 4'b1000, 8'h3C, 0);
        add(4'b1000, 0, 8'h00, 4'b0000, 1, 0, 4'b0000, 8'h00, 1);
        add(4'b1000, 0, 8'h00, 4'b0000, 0, 0, 4'b0000, 8'h00, 1);
        add(4'b1000, 1, 8'h5A, 4'b0000, 0, 0, 4'b0000, 8'h00, 1);
        add(4'b1000, 0, 8'h00, 4'b1000, 0, 0, 4'b0001, 8'h5A, 0);
        add(4'b0000, 0, 8'h00, 4'b0000, 1, 3, 4'b0000, 8'h00, 1);
        add(4'b0000, 0, 8'h00, 4'b0000, 0, 0, 4'b0000, 8'h00, 1);
        add(4'b0000, 1, 8'h77, 4'b0000, 0, 0, 4'b0000, 8'h00, 1);
        add(4'b0000, 0, 8'h00, 4'b0000, 0, 0, 4'b1000, 8'h77, 0);
        // All four valid continuously: grants 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            add(4'b1111, 0, 8'h00, 4'(1 << (k % 4)), 0, 0,
                (k == 0) ? 4'b0000 : 4'(1 << ((k - 1) % 4)), 8'(8'h10 + k - 1), 0);
            add(4'b1111, 0, 8'h00, 4'b0000, 1, 2'(k % 4), 4'b0000, 8'h00, 1);
            add(4'b1111, 0, 8'h00, 4'b0000, 0, 0, 4'b0000, 8'h00, 1);
            add(4'b1111, 1, 8'(8'h10 + k), 4'b0000, 0, 0, 4'b0000, 8'h00, 1);
        end
        add(4'b0000, 0, 8'h00, 4'b0000, 0, 0, 4'b0001, 8'h14, 0);

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 512'(req_ready), 512'(0));
        chk("rst_rv", 512'(resp_valid), 512'(0));
        chk("rst_snp", 512'(snp_req_valid), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_err", 512'(resp_err), 512'(0));
        chk("rst_data", resp_data, 512'(0));
        chk("rst_paddr", 512'(snp_req_paddr), 512'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].valid, vecs[i].rsp, vecs[i].seed);
            for (int j = 0; j < 4; j++) if (req_ready[j]) gcnt[j]++;
            chk($sformatf("v%0d_ready", i), 512'(req_ready), 512'(vecs[i].ex_ready));
            chk($sformatf("v%0d_snp", i), 512'(snp_req_valid), 512'(vecs[i].ex_snp));
            chk($sformatf("v%0d_rv", i), 512'(resp_valid), 512'(vecs[i].ex_rv));
            chk($sformatf("v%0d_busy", i), 512'(busy), 512'(vecs[i].ex_busy));
            if (vecs[i].ex_snp)
                chk($sformatf("v%0d_paddr", i), 512'(snp_req_paddr), 512'(req_paddr[vecs[i].ex_pid]));
            if (vecs[i].ex_rv != 4'b0000)
                chk_resp($sformatf("v%0d", i), vecs[i].ex_rv, vecs[i].ex_seed);
        end
        chk("gcnt0", 512'(gcnt[0]), 512'(3));
        chk("gcnt1", 512'(gcnt[1]), 512'(1));
        chk("gcnt2", 512'(gcnt[2]), 512'(2));
        chk("gcnt3", 512'(gcnt[3]), 512'(3));

        // Reset while waiting for a response (pointer is 1 here).
        step(4'b0010, 0, 8'h00);
        chk("rs_ready", 512'(req_ready), 512'(4'b0010));
        step(4'b0000, 0, 8'h00);
        chk("rs_snp", 512'(snp_req_valid), 512'(1));
        step(4'b0000, 0, 8'h00);
        chk("rs_wait_busy", 512'(busy), 512'(1));
        rst_n = 1'b0;
        #1;
        chk("rs_busy", 512'(busy), 512'(0));
        chk("rs_snp0", 512'(snp_req_valid), 512'(0));
        chk("rs_rv0", 512'(resp_valid), 512'(0));
        chk("rs_paddr0", 512'(snp_req_paddr), 512'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        step(4'b0000, 1, 8'hAB);
        chk("stale_busy", 512'(busy), 512'(0));
        step(4'b0000, 0, 8'h00);
        chk("stale_rv", 512'(resp_valid), 512'(0));
        chk("stale_busy2", 512'(busy), 512'(0));
        step(4'b1111, 0, 8'h00);
        chk("rs_ptr0", 512'(req_ready), 512'(4'b0001));
        step(4'b0000, 0, 8'h00);
        chk("rs_paddr", 512'(snp_req_paddr), 512'(req_paddr[0]));
        step(4'b0000, 0, 8'h00);
        step(4'b0000, 1, 8'h99);
        step(4'b0000, 0, 8'h00);
        chk_resp("rs_resp", 4'b0001, 8'h99);

`ifdef MSRH_SNOOP_ARB_TIMEOUT_EN
        // Watchdog: 16 WAIT_RESP cycles without response.
        step(4'b0100, 0, 8'h00);
        chk("to_ready", 512'(req_ready), 512'(4'b0100));
        step(4'b0000, 0, 8'h00);
        chk("to_snp", 512'(snp_req_valid), 512'(1));
        for (int j = 0; j < 16; j++) begin
            step(4'b0000, 0, 8'h00);
            chk($sformatf("to_w%0d_rv", j), 512'(resp_valid), 512'(0));
        end
        step(4'b0001, 0, 8'h00);
        chk("to_rv", 512'(resp_valid), 512'(4'b0100));
        chk("to_err", 512'(resp_err), 512'(1));
        chk("to_be", 512'(resp_be), 512'(0));
        chk("to_data", resp_data, 512'(0));
        chk("to_drain_ready", 512'(req_ready), 512'(0));
        chk("to_drain_busy", 512'(busy), 512'(1));
        step(4'b0001, 1, 8'hEE);
        chk("to_late_ready", 512'(req_ready), 512'(0));
        step(4'b0001, 0, 8'h00);
        chk("to_late_rv", 512'(resp_valid), 512'(0));
        chk("to_idle_busy", 512'(busy), 512'(0));
        chk("to_idle_ready", 512'(req_ready), 512'(4'b0001));
        step(4'b0000, 0, 8'h00);
        step(4'b0000, 0, 8'h00);
        step(4'b0000, 1, 8'hC3);
        step(4'b0000, 0, 8'h00);
        chk_resp("to_after", 4'b0001, 8'hC3);
`else
        // Without the watchdog a long wait produces no response.
        step(4'b0100, 0, 8'h00);
        chk("nt_ready", 512'(req_ready), 512'(4'b0100));
        step(4'b0000, 0, 8'h00);
        chk("nt_snp", 512'(snp_req_valid), 512'(1));
        for (int j = 0; j < 20; j++) begin
            step(4'b0000, 0, 8'h00);
            chk($sformatf("nt_w%0d_rv", j), 512'(resp_valid), 512'(0));
            chk($sformatf("nt_w%0d_busy", j), 512'(busy), 512'(1));
        end
        step(4'b0000, 1, 8'hC3);
        step(4'b0000, 0, 8'h00);
        chk_resp("nt_resp", 4'b0100, 8'hC3);
        chk("nt_busy", 512'(busy), 512'(0));
`endif

        w1 = req_ready;
        chk("end_ready", 512'(w1), 512'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msrh_snoop_req_arb.md
# msrh_snoop_req_arb

Shares the single snoop unit between REQ_N coherence requesters, such as L2 or bus-side agents.
- Round-robin arbitration selects one requester at a time.
- The winner's snoop is issued as a one-cycle request pulse.
- The arbiter waits for the merged L1D/STQ response and routes data/byte-enables back to the originating requester.
- Sits between the external coherence fabric and the snoop unit.
- Only one snoop is in flight at any time.

## Interface
Parameters:
- REQ_N, 4: number of snoop requesters (≥2).
- PADDR_W, 56: physical address width.
- DATA_W, 512: snoop data width (= DCACHE_DATA_W); byte-enable width DATA_W/8.
- TIMEOUT_CYC, 1024: watchdog limit in cycles (used only with timeout feature).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req_valid  in  REQ_N  requester snoop request valid; held until ready.
- i_req_paddr  in  REQ_N×PADDR_W  per-requester snoop address.
- o_req_ready  out  REQ_N  one-hot accept; request fires when valid & ready.
- o_resp_valid  out  REQ_N  one-hot, one-cycle response pulse to originator.
- o_resp_data  out  DATA_W  response data, shared bus.
- o_resp_be  out  DATA_W/8  response byte-enables, shared bus.
- o_resp_err  out  1  response is a timeout error (0 when feature compiled out).
- o_snp_req_valid  out  1  one-cycle request pulse to snoop unit.
- o_snp_req_paddr  out  PADDR_W  address to snoop unit, unmodified (snoop unit line-aligns).
- i_snp_resp_valid  in  1  snoop unit merged response pulse.
- i_snp_resp_data  in  DATA_W  merged data.
- i_snp_resp_be  in  DATA_W/8  merged byte-enables.
- o_busy  out  1  state ≠ IDLE.

## Operation
FSM states IDLE, ISSUE, WAIT_RESP, DRAIN.
- IDLE:
  - If any i_req_valid, the round-robin winner gets o_req_ready combinationally in the same cycle.
  - Latch the paddr and the winner id; go to ISSUE.
  - o_req_ready is all-zero in every other state.
- ISSUE:
  - o_snp_req_valid=1 for exactly one cycle; go to WAIT_RESP.
  - o_snp_req_valid must never be high two consecutive cycles, because the snoop unit re-triggers on a level.
- WAIT_RESP:
  - On i_snp_resp_valid, register data/be.
  - Next cycle, o_resp_valid[id]=1 with o_resp_data/o_resp_be valid and o_resp_err=0.
  - Go to IDLE in that same registered update.
- DRAIN: used only by the timeout feature (see Configuration).
- Round-robin pointer:
  - Reset value 0.
  - After granting requester i, the highest priority becomes (i+1) mod REQ_N.
  - The search wraps from REQ_N-1 to 0.
- i_snp_resp_valid outside WAIT_RESP/DRAIN: ignored; a SIMULATION assertion fires.
- Requesters deasserting valid before ready: legal; nothing is latched for them.

## Timing
- Reset values: state IDLE, rr pointer 0, o_snp_req_valid 0, o_resp_valid 0, o_resp_err 0, o_busy 0, data/be/paddr registers 0.
- Grant cycle T (IDLE, valid&ready) → o_snp_req_valid at T+1 → earliest i_snp_resp_valid T+3 → o_resp_valid T+4.
- Back-to-back: a new grant is possible in the same cycle o_resp_valid is high, since state is already IDLE.
- Reset mid-operation: all state is discarded, with no response to the in-flight requester. Requesters must reissue.

## Configuration
- MSRH_SNOOP_ARB_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to WAIT_RESP and increments each WAIT_RESP cycle.
  - When the counter reaches TIMEOUT_CYC-1 without a response, the arbiter sends o_resp_valid[id] with data 0, be 0, o_resp_err=1, then enters DRAIN.
  - DRAIN holds o_busy=1 and grants nothing. It discards the next i_snp_resp_valid, then returns to IDLE.
  - A response arriving in the same cycle the counter hits the limit is treated as normal, with no error.
- Undefined: no counter and no DRAIN state; o_resp_err tied 0; WAIT_RESP waits indefinitely.

## Test plan
- Single request: req 2 valid, paddr 0x8000_1040; response be=all-ones, data pattern → ready[2] at T, snp pulse at T+1 only, o_resp_valid=4'b0100 one cycle with matching data/be.
- All four valid continuously from reset → grant order 0,1,2,3,0; each granted once per four snoops.
- Requester 3 granted, then requesters 0 and 3 valid → grant 0 (wrap), then 3.
- Response arrives while a new request is pending → o_resp_valid and the next o_req_ready in the same cycle; exactly one snp pulse per grant.
- Timeout (macro on, TIMEOUT_CYC=16), no response for 16 cycles → o_resp_err=1, be=0. A late response is dropped with no o_resp_valid, then IDLE.
- Reset asserted in WAIT_RESP → all outputs 0 immediately. After release, a stale i_snp_resp_valid produces no o_resp_valid.
